// File: rtl/rad_cdc_hs_tx.sv
// Source side of a 2-phase req/ack CDC handshake carrying a WIDTH-bit word.
// Optional watchdog: define RAD_CDC_HS_TX_TIMEOUT_EN to build the sticky timeout flag.

module rad_cdc_sync #(
    parameter int STAGES = 2,
    parameter bit RESET  = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sync_ff <= {STAGES{RESET}};
        else
            sync_ff <= {sync_ff[STAGES-2:0], d};
    end

    assign q = sync_ff[STAGES-1];

endmodule

module rad_cdc_hs_tx #(
    parameter int WIDTH          = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             src_valid_i,
    output logic             src_ready_o,
    input  logic [WIDTH-1:0] src_data_i,
    output logic             req_o,
    output logic [WIDTH-1:0] data_o,
    input  logic             ack_async_i,
    output logic             done_o,
    output logic             timeout_o
);

    if (WIDTH < 1) begin : g_bad_width
        $error("rad_cdc_hs_tx: WIDTH must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_stages
        $error("rad_cdc_hs_tx: SYNC_STAGES must be >= 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("rad_cdc_hs_tx: TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic {IDLE, WAIT_ACK} state_t;

    state_t           state, state_next;
    logic             req_next, done_next;
    logic [WIDTH-1:0] data_next;
    logic             ack_sync;

    rad_cdc_sync #(
        .STAGES (SYNC_STAGES),
        .RESET  (1'b0)
    ) u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ack_async_i),
        .q     (ack_sync)
    );

    // The transfer completes once the synchronized ack parity catches up with req.
    always_comb begin
        state_next = state;
        req_next   = req_o;
        data_next  = data_o;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (src_valid_i) begin
                    data_next  = src_data_i;
                    req_next   = ~req_o;
                    state_next = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (ack_sync == req_o) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            req_o  <= 1'b0;
            data_o <= '0;
            done_o <= 1'b0;
        end else begin
            state  <= state_next;
            req_o  <= req_next;
            data_o <= data_next;
            done_o <= done_next;
        end
    end

    assign src_ready_o = (state == IDLE);

`ifdef RAD_CDC_HS_TX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_q;

    // Flag only; the FSM keeps waiting so the toggle parity is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else if (state == IDLE && src_valid_i) begin
            wait_cnt <= '0;
        end else if (state == WAIT_ACK && wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == CNT_MAX - 1'b1)
                timeout_q <= 1'b1;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_rad_cdc_hs_tx.sv
// Directed bench for rad_cdc_hs_tx; the bench plays the destination receiver.
// With RAD_CDC_HS_TX_TIMEOUT_EN defined the timeout expectations switch on.

module tb_rad_cdc_hs_tx;

    localparam int WIDTH = 8;
    localparam int SYNC  = 2;
`ifdef RAD_CDC_HS_TX_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             src_valid_i = 1'b0;
    logic             src_ready_o;
    logic [WIDTH-1:0] src_data_i = '0;
    logic             req_o;
    logic [WIDTH-1:0] data_o;
    logic             ack_async_i;
    logic             done_o;
    logic             timeout_o;

    logic             ack_manual = 1'b0;
    logic             ack_rx = 1'b0;
    logic             rx_en = 1'b0;
    logic [WIDTH-1:0] rx_q[$];
    int               done_cnt = 0;
    int               n_cmp = 0;
    int               n_err = 0;

    assign ack_async_i = rx_en ? ack_rx : ack_manual;

    rad_cdc_hs_tx #(
        .WIDTH          (WIDTH),
        .SYNC_STAGES    (SYNC),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .src_valid_i (src_valid_i),
        .src_ready_o (src_ready_o),
        .src_data_i  (src_data_i),
        .req_o       (req_o),
        .data_o      (data_o),
        .ack_async_i (ack_async_i),
        .done_o      (done_o),
        .timeout_o   (timeout_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && done_o)
            done_cnt = done_cnt + 1;
    end

    // Receiver model: answers each req toggle after a random 0-7 cycle delay.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (!rx_en) begin
                ack_rx = ack_manual;
            end else if (req_o != ack_rx) begin
                repeat ($urandom_range(0, 7)) @(posedge clk);
                #2;
                rx_q.push_back(data_o);
                ack_rx = req_o;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no finish want finish before 2ms");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rx_en       = 1'b0;
        src_valid_i = 1'b0;
        ack_manual  = 1'b0;
        rst_n       = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        n_cmp++;
        if (req_o !== 1'b0 || data_o !== 8'h00) begin
            n_err++;
            $display("[TB] FAIL reset_regs: got req=%0b data=%h want req=0 data=00", req_o, data_o);
        end
        n_cmp++;
        if (src_ready_o !== 1'b1 || done_o !== 1'b0 || timeout_o !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL reset_flags: got rdy=%0b done=%0b to=%0b want 1/0/0", src_ready_o, done_o, timeout_o);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            n_cmp++;
            if (req_o !== 1'b0 || data_o !== 8'h00 || src_ready_o !== 1'b1 || done_o !== 1'b0) begin
                n_err++;
                $display("[TB] FAIL idle_stable[%0d]: got req=%0b data=%h rdy=%0b done=%0b want 0/00/1/0", i, req_o, data_o, src_ready_o, done_o);
            end
        end
    endtask

    task automatic test_reset_mid();
        src_data_i  = 8'h3C;
        src_valid_i = 1'b1;
        step();
        src_valid_i = 1'b0;
        n_cmp++;
        if (data_o !== 8'h3C || req_o !== 1'b1 || src_ready_o !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL mid_accept: got data=%h req=%0b rdy=%0b want 3C/1/0", data_o, req_o, src_ready_o);
        end
        step();
        #2;
        ack_manual = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (req_o !== 1'b0 || data_o !== 8'h00 || src_ready_o !== 1'b1 || done_o !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL mid_reset: got req=%0b data=%h rdy=%0b done=%0b want 0/00/1/0", req_o, data_o, src_ready_o, done_o);
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            n_cmp++;
            if (done_o !== 1'b0 || src_ready_o !== 1'b1) begin
                n_err++;
                $display("[TB] FAIL mid_no_done[%0d]: got done=%0b rdy=%0b want 0/1", i, done_o, src_ready_o);
            end
        end
    endtask

    task automatic test_single();
        src_data_i  = 8'hA5;
        src_valid_i = 1'b1;
        step();
        src_valid_i = 1'b0;
        n_cmp++;
        if (data_o !== 8'hA5 || req_o !== 1'b1 || src_ready_o !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL single_accept: got data=%h req=%0b rdy=%0b want A5/1/0", data_o, req_o, src_ready_o);
        end
        repeat (3) step();
        ack_manual = 1'b1;
        for (int i = 1; i <= SYNC + 1; i++) begin
            step();
            n_cmp++;
            if (done_o !== (i == SYNC + 1) || src_ready_o !== (i == SYNC + 1)) begin
                n_err++;
                $display("[TB] FAIL single_done[%0d]: got done=%0b rdy=%0b want %0b", i, done_o, src_ready_o, (i == SYNC + 1));
            end
        end
        step();
        n_cmp++;
        if (done_o !== 1'b0 || data_o !== 8'hA5) begin
            n_err++;
            $display("[TB] FAIL single_pulse_end: got done=%0b data=%h want 0/A5", done_o, data_o);
        end
    endtask

    task automatic test_backpressure();
        bit seen;
        src_data_i  = 8'h01;
        src_valid_i = 1'b1;
        step();
        src_data_i = 8'h02;
        n_cmp++;
        if (data_o !== 8'h01 || req_o !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL bp_first: got data=%h req=%0b want 01/0", data_o, req_o);
        end
        repeat (2) step();
        ack_manual = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (done_o) begin
                seen = 1'b1;
            end else begin
                n_cmp++;
                if (data_o !== 8'h01) begin
                    n_err++;
                    $display("[TB] FAIL bp_hold[%0d]: got data=%h want 01", i, data_o);
                end
            end
        end
        n_cmp++;
        if (!seen || src_ready_o !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL bp_done: got seen=%0b rdy=%0b want 1/1", seen, src_ready_o);
        end
        step();
        src_valid_i = 1'b0;
        n_cmp++;
        if (data_o !== 8'h02 || req_o !== 1'b1 || src_ready_o !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL bp_second: got data=%h req=%0b rdy=%0b want 02/1/0", data_o, req_o, src_ready_o);
        end
        ack_manual = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            seen = done_o;
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("[TB] FAIL bp_second_done: got no done want done within 10 cycles");
        end
    endtask

    task automatic test_stream();
        logic [WIDTH-1:0] words[16];
        int               base;
        int               guard;
        for (int k = 0; k < 16; k++)
            words[k] = WIDTH'(k * 8'h1D + 8'h07);
        rx_q.delete();
        base  = done_cnt;
        rx_en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            src_data_i  = words[k];
            src_valid_i = 1'b1;
            guard = 0;
            while (!src_ready_o && guard < 100) begin
                step();
                guard++;
            end
            step();
            src_valid_i = 1'b0;
        end
        guard = 0;
        while ((rx_q.size() < 16 || done_cnt - base < 16) && guard < 200) begin
            step();
            guard++;
        end
        step();
        n_cmp++;
        if (rx_q.size() != 16 || done_cnt - base != 16) begin
            n_err++;
            $display("[TB] FAIL stream_count: got rx=%0d done=%0d want 16/16", rx_q.size(), done_cnt - base);
        end
        for (int k = 0; k < 16 && k < rx_q.size(); k++) begin
            n_cmp++;
            if (rx_q[k] !== words[k]) begin
                n_err++;
                $display("[TB] FAIL stream_word[%0d]: got %h want %h", k, rx_q[k], words[k]);
            end
        end
        n_cmp++;
        if (req_o !== 1'b0 || src_ready_o !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL stream_end: got req=%0b rdy=%0b want 0/1", req_o, src_ready_o);
        end
    endtask

    task automatic test_timeout();
        bit seen;
        src_data_i  = 8'h5A;
        src_valid_i = 1'b1;
        step();
        src_valid_i = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            step();
            n_cmp++;
            if (timeout_o !== (TO_EN && i >= 8) || src_ready_o !== 1'b0) begin
                n_err++;
                $display("[TB] FAIL timeout_wait[%0d]: got to=%0b rdy=%0b want %0b/0", i, timeout_o, src_ready_o, (TO_EN && i >= 8));
            end
        end
        ack_manual = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            seen = done_o;
        end
        n_cmp++;
        if (!seen || timeout_o !== TO_EN) begin
            n_err++;
            $display("[TB] FAIL timeout_late_ack: got done=%0b to=%0b want 1/%0b", seen, timeout_o, TO_EN);
        end
        repeat (3) step();
        n_cmp++;
        if (timeout_o !== TO_EN || src_ready_o !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL timeout_sticky: got to=%0b rdy=%0b want %0b/1", timeout_o, src_ready_o, TO_EN);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_single();
        test_backpressure();
        do_reset();
        test_stream();
        do_reset();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
